// File: rtl/mux4x1_seq_if.sv
// Channel-word handshake bundle for mux4x1_seq: parallel word in, serial bit out.
interface mux4x1_seq_if;
   logic [3:0] in;
   logic [3:0] en;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] s;
   logic       y;
   logic       y_valid;
   logic       y_ready;
   logic       y_last;
   logic       busy;

   // Producer / consumer side (drives the word, accepts the serial stream)
   modport master (
      output in, en, in_valid, y_ready,
      input  in_ready, s, y, y_valid, y_last, busy
   );

   // Block side
   modport slave (
      input  in, en, in_valid, y_ready,
      output in_ready, s, y, y_valid, y_last, busy
   );
endinterface

// File: rtl/mux4x1_seq.sv
// Sequential 4:1 mux: latches a 4-bit word plus enable mask, then emits the
// enabled channels one per transfer in ascending index order.
module mux4x1_seq #(
   parameter int unsigned USE_MASK = 1
) (
   input logic         clk,
   input logic         rst_n,
   mux4x1_seq_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [0:0] state_q, state_d;
   logic [1:0] s_q, s_d;
   logic [3:0] data_q, data_d;
   logic [3:0] mask_q, mask_d;

   logic [3:0] eff_mask_s;
   logic [3:0] rest_mask_s;
   logic       scan_s;
   logic       last_s;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [1:0] lowest_set(input logic [3:0] m);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) begin
            idx = 2'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Mask of channel positions strictly above idx.
   function automatic logic [3:0] above_mask(input logic [1:0] idx);
      logic [3:0] m;
      case (idx)
         2'd0:    m = 4'b1110;
         2'd1:    m = 4'b1100;
         2'd2:    m = 4'b1000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   assign eff_mask_s  = (USE_MASK != 0) ? bus.en : 4'b1111;
   assign rest_mask_s = mask_q & above_mask(s_q);
   assign scan_s      = (state_q == ST_SCAN);
   assign last_s      = (rest_mask_s == 4'b0000);

   // Outputs are pure decodes of registered state.
   assign bus.in_ready = ~scan_s;
   assign bus.y_valid  = scan_s;
   assign bus.busy     = scan_s;
   assign bus.y_last   = scan_s & last_s;
   assign bus.s        = s_q;
   assign bus.y        = data_q[s_q];

   // Next-state: accept a word in IDLE, step through enabled channels in SCAN.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      data_d  = data_q;
      mask_d  = mask_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               data_d = bus.in;
               mask_d = eff_mask_s;
               if (eff_mask_s != 4'b0000) begin
                  state_d = ST_SCAN;
                  s_d     = lowest_set(eff_mask_s);
               end else begin
                  // empty mask: word is dropped, stay idle
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (bus.y_ready) begin
               if (last_s) begin
                  state_d = ST_IDLE;
               end else begin
                  s_d = lowest_set(rest_mask_s);
               end
            end else begin
               // stall: everything holds
               state_d = ST_SCAN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= 2'd0;
         data_q  <= 4'b0000;
         mask_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

endmodule

// File: doc/mux4x1_seq.md
MUX4X1_SEQ -- requirements
Module: mux4x1_seq

Interface
REQ-001 Parameter: USE_MASK, default 1. When 1, the en mask is honoured; when 0, en is ignored and all four channels are scanned.
REQ-002 Port: clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  Synchronous, active-low reset; sampled on the rising clk edge.
REQ-004 Port: in  input  4  Parallel channel word; bit i is channel i.
REQ-005 Port: en  input  4  Channel enable mask; bit i set means channel i is emitted.
REQ-006 Port: in_valid  input  1  Upstream offers in/en this cycle.
REQ-007 Port: in_ready  output  1  Block can accept a word this cycle.
REQ-008 Port: s  output  2  Select index of the channel currently presented on y (drives a 4x1 mux select).
REQ-009 Port: y  output  1  Serial data bit: the latched word indexed by s.
REQ-010 Port: y_valid  output  1  y, s and y_last are meaningful.
REQ-011 Port: y_ready  input  1  Downstream accepts y this cycle.
REQ-012 Port: y_last  output  1  Current y is the final enabled channel of the word.
REQ-013 Port: busy  output  1  A word is latched and not fully emitted.

Function
REQ-014 The block SHALL have exactly two states: IDLE and SCAN.
REQ-015 In IDLE, in_ready SHALL be 1, and y_valid, y_last and busy SHALL be 0.
REQ-016 In SCAN, in_ready SHALL be 0; busy and y_valid SHALL be 1.
REQ-017 Accept: in_valid=1 and in_ready=1 at an edge SHALL latch in into data_q and the effective mask into mask_q (en if USE_MASK=1, else 4'b1111).
REQ-018 If the effective mask is 0 at accept, the word SHALL be dropped, the state SHALL remain IDLE, and no y_valid SHALL be produced.
REQ-019 If the effective mask is non-zero at accept, the next state SHALL be SCAN and s SHALL be set to the lowest set bit index of the mask.
REQ-020 First y_valid SHALL appear the cycle after accept (1-cycle latency); all outputs SHALL be registered or decoded purely from registered state.
REQ-021 y SHALL equal data_q[s] in every SCAN cycle.
REQ-022 y_last SHALL be 1 iff no bit of mask_q above index s is set.
REQ-023 Transfer: y_valid=1 and y_ready=1 at an edge SHALL complete one channel.
- With y_last=0: s SHALL advance to the next higher set bit of mask_q, skipping disabled channels.
- With y_last=1: the state SHALL return to IDLE.
REQ-024 Stall: with y_valid=1 and y_ready=0, s, y, y_last, data_q and mask_q SHALL hold unchanged.
REQ-025 Changes on in/en during SCAN SHALL NOT affect the word being emitted.
REQ-026 s SHALL never wrap from 3 to 0 within a word; channels are emitted in strictly ascending index order.
REQ-027 The number of transfers per word SHALL equal the popcount of the effective mask (1..4).
REQ-028 Back-to-back: the earliest next accept SHALL be the IDLE cycle after the y_last transfer (one idle cycle between words).
REQ-029 y_ready SHALL be ignored in IDLE.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, s=0, data_q=0, mask_q=0, y_valid=0, y_last=0, busy=0, and in_ready=1 from the following cycle.
REQ-031 Reset asserted mid-SCAN SHALL abandon the word with no further y_valid; an in_valid coincident with reset SHALL NOT be accepted.
REQ-032 After release, the block SHALL accept on the first edge with rst_n=1 and in_valid=1.

Verification
REQ-033 Full mask: in=4'b1010, en=4'b1111, y_ready=1 -> y sequence 0,1,0,1 with s=0,1,2,3 on consecutive cycles; y_last only at s=3; in_ready returns to 1 the next cycle.
REQ-034 Sparse mask: in=4'b0110, en=4'b1010 -> two transfers: (s=1,y=1), then (s=3,y=0,y_last=1).
REQ-035 Empty mask: en=4'b0000, in_valid pulse -> in_ready stays 1, y_valid stays 0, busy stays 0.
REQ-036 Backpressure: en=4'b1111, y_ready low for 3 cycles at s=2 -> s=2 and y hold for all 3 cycles; the scan completes normally once y_ready rises.
REQ-037 Reset mid-scan: rst_n=0 at s=1 -> next cycle y_valid=0, s=0, in_ready=1; a new word then scans correctly.
REQ-038 USE_MASK=0: en=4'b0001, in=4'b1111 -> four transfers, all y=1.
